// File: rtl/divider16_seq.sv
// divider16_seq: multi-cycle unsigned restoring divider.
// One shift-subtract step per clock behind a start/busy/done handshake.
module divider16_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    // Partial remainder stays below 2^(WIDTH-1) until the final step,
    // whose full-width result goes straight into rem_q.
    logic [WIDTH-2:0] r_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dz_q;

    logic [WIDTH-1:0] r_sh;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        r_sh = {r_q, q_q[WIDTH-1]};
        t    = {1'b0, r_sh} - {1'b0, d_q};
        r_d  = t[WIDTH] ? r_sh : t[WIDTH-1:0];
        q_d  = {q_q[WIDTH-2:0], ~t[WIDTH]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            q_q     <= dividend;
                            d_q     <= divisor;
                            r_q     <= '0;
                            cnt_q   <= '0;
                            quot_q  <= '0;
                            rem_q   <= '0;
                            dz_q    <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    q_q   <= q_d;
                    r_q   <= r_d[WIDTH-2:0];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= q_d;
                        rem_q   <= r_d;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;

endmodule
